// File: rtl/alu_pkg.sv
// Shared constants, opcode/compare encodings and FSM states for the nibble-serial ALU.
// Optional feature macro: ALU_CMP_EXT_EN (full compare-code set for op 7).
package alu_pkg;

    localparam int DATA_W  = 32;
    localparam int SLICE_W = 4;
    localparam int NIBBLES = DATA_W / SLICE_W;
    localparam int CNT_W   = 3;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_CMP  = 4'd7;
    localparam logic [3:0] OP_NOR  = 4'd12;
    localparam logic [3:0] OP_NAND = 4'd13;

    localparam logic [2:0] CMP_SLT = 3'd0;
    localparam logic [2:0] CMP_SGT = 3'd1;
    localparam logic [2:0] CMP_SLE = 3'd2;
    localparam logic [2:0] CMP_SGE = 3'd3;
    localparam logic [2:0] CMP_SNE = 3'd4;
    localparam logic [2:0] CMP_SEQ = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic is_logic_op(input logic [3:0] op);
        return (op == OP_AND) || (op == OP_OR) || (op == OP_NOR) || (op == OP_NAND);
    endfunction

    function automatic logic is_arith_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_CMP);
    endfunction

    function automatic logic cmp_legal(input logic [2:0] c);
        return (c == CMP_SLT) || (c == CMP_SGT) || (c == CMP_SLE) ||
               (c == CMP_SGE) || (c == CMP_SNE) || (c == CMP_SEQ);
    endfunction

endpackage

// File: rtl/alu_nibble_adder.sv
// 4-bit combinational adder slice; c3 is the carry into the slice MSB so the
// caller can form signed overflow on the top nibble.
module alu_nibble_adder
    import alu_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout,
    output logic               c3
);

    logic [SLICE_W-1:0] low;
    logic [1:0]         high;

    // Split below the MSB so the internal carry is visible.
    assign low  = {1'b0, a[SLICE_W-2:0]} + {1'b0, b[SLICE_W-2:0]} + {{(SLICE_W-1){1'b0}}, cin};
    assign c3   = low[SLICE_W-1];
    assign high = {1'b0, a[SLICE_W-1]} + {1'b0, b[SLICE_W-1]} + {1'b0, c3};
    assign sum  = {high[0], low[SLICE_W-2:0]};
    assign cout = high[1];

endmodule

// File: rtl/alu_seq_responder.sv
// Handshaked ALU: logical ops in one cycle, ADD/SUB/CMP nibble-serially over 8 cycles.
// Optional feature macro: ALU_CMP_EXT_EN (all six compare codes; otherwise CMP is SLT).
module alu_seq_responder
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_src1,
    input  logic [DATA_W-1:0] req_src2,
    input  logic [3:0]        req_op,
    input  logic [2:0]        req_cmp,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_cout,
    output logic              rsp_overflow,
    output logic              rsp_err
);

    state_t            state, state_nxt;
    logic [DATA_W-1:0] a_q, b_q, res_q;
    logic [3:0]        op_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              carry_q;
    logic              zero_q, cout_q, ovf_q, err_q;

    logic              accept, req_arith, req_illegal, last_nib;
    logic [DATA_W-1:0] logic_res, diff;
    logic [SLICE_W-1:0] sl_a, sl_b, sl_sum;
    logic              sl_cout, sl_c3, fin_ovf, lt, eq, cmp_bit;

`ifdef ALU_CMP_EXT_EN
    logic [2:0]        cmp_q;
`else
    logic              cmp_unused;
    assign cmp_unused = ^req_cmp;
`endif

    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign accept    = req_valid && req_ready;
    assign last_nib  = (cnt_q == CNT_W'(NIBBLES - 1));

    always_comb begin
        req_arith   = is_arith_op(req_op);
        req_illegal = !(req_arith || is_logic_op(req_op));
`ifdef ALU_CMP_EXT_EN
        if (req_op == OP_CMP && !cmp_legal(req_cmp))
            req_illegal = 1'b1;
`endif
    end

    always_comb begin
        logic_res = '0;
        case (req_op)
            OP_AND:  logic_res = req_src1 & req_src2;
            OP_OR:   logic_res = req_src1 | req_src2;
            OP_NOR:  logic_res = ~(req_src1 | req_src2);
            OP_NAND: logic_res = ~(req_src1 & req_src2);
            default: logic_res = '0;
        endcase
    end

    // One slice, stepped across the operands by the nibble counter.
    assign sl_a = a_q[cnt_q*SLICE_W +: SLICE_W];
    assign sl_b = b_q[cnt_q*SLICE_W +: SLICE_W];

    alu_nibble_adder u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry_q),
        .sum  (sl_sum),
        .cout (sl_cout),
        .c3   (sl_c3)
    );

    // Only meaningful on the last nibble, when the top slice is in the adder.
    assign diff    = {sl_sum, res_q[DATA_W-SLICE_W-1:0]};
    assign fin_ovf = sl_c3 ^ sl_cout;
    assign lt      = diff[DATA_W-1] ^ fin_ovf;
    assign eq      = (diff == '0);

    always_comb begin
        cmp_bit = lt;
`ifdef ALU_CMP_EXT_EN
        case (cmp_q)
            CMP_SGT: cmp_bit = !lt && !eq;
            CMP_SLE: cmp_bit = lt || eq;
            CMP_SGE: cmp_bit = !lt;
            CMP_SNE: cmp_bit = !eq;
            CMP_SEQ: cmp_bit = eq;
            default: cmp_bit = lt;
        endcase
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = (req_arith && !req_illegal) ? ST_EXEC : ST_RESP;
            ST_EXEC: if (last_nib) state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
`ifdef ALU_CMP_EXT_EN
            cmp_q   <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: if (accept) begin
                    // SUB/CMP run as A + ~B + 1.
                    a_q     <= req_src1;
                    b_q     <= (req_op == OP_ADD) ? req_src2 : ~req_src2;
                    carry_q <= (req_op != OP_ADD);
                    op_q    <= req_op;
                    cnt_q   <= '0;
                    cout_q  <= 1'b0;
                    ovf_q   <= 1'b0;
`ifdef ALU_CMP_EXT_EN
                    cmp_q   <= req_cmp;
`endif
                    if (req_illegal) begin
                        res_q  <= '0;
                        zero_q <= 1'b1;
                        err_q  <= 1'b1;
                    end else if (!req_arith) begin
                        res_q  <= logic_res;
                        zero_q <= (logic_res == '0);
                        err_q  <= 1'b0;
                    end else begin
                        res_q  <= '0;
                        zero_q <= 1'b0;
                        err_q  <= 1'b0;
                    end
                end
                ST_EXEC: begin
                    carry_q <= sl_cout;
                    cnt_q   <= cnt_q + 1'b1;
                    if (!last_nib) begin
                        res_q[cnt_q*SLICE_W +: SLICE_W] <= sl_sum;
                    end else if (op_q == OP_CMP) begin
                        res_q  <= {{(DATA_W-1){1'b0}}, cmp_bit};
                        zero_q <= !cmp_bit;
                    end else begin
                        res_q  <= diff;
                        zero_q <= eq;
                        cout_q <= sl_cout;
                        ovf_q  <= fin_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_result   = res_q;
    assign rsp_zero     = zero_q;
    assign rsp_cout     = cout_q;
    assign rsp_overflow = ovf_q;
    assign rsp_err      = err_q;

endmodule

// File: tb/tb_alu_seq_responder.sv
// Randomized + directed bench for alu_seq_responder against an arithmetic reference model.
// Honours ALU_CMP_EXT_EN the same way the design does.
module tb_alu_seq_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_src1 = '0;
    logic [31:0] req_src2 = '0;
    logic [3:0]  req_op = '0;
    logic [2:0]  req_cmp = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic        rsp_zero, rsp_cout, rsp_overflow, rsp_err;

    always #5 clk = ~clk;

    alu_seq_responder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_src1     (req_src1),
        .req_src2     (req_src2),
        .req_op       (req_op),
        .req_cmp      (req_cmp),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_zero     (rsp_zero),
        .rsp_cout     (rsp_cout),
        .rsp_overflow (rsp_overflow),
        .rsp_err      (rsp_err)
    );

    typedef struct {
        logic [31:0] res;
        logic        zero, cout, ovf, err;
        int          lat;
        int          acc;
        bit          seen;
    } exp_t;

    typedef struct {
        logic [31:0] res;
        logic        zero, cout, ovf, err;
    } rsp_t;

    exp_t q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   chk_en = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic finish_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    // Reference: what the response must be, from plain 33-bit and signed arithmetic.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] cmp);
        exp_t e;
        logic [32:0] s;
        logic lt, eq, r;
        e.res = '0; e.zero = 0; e.cout = 0; e.ovf = 0; e.err = 0;
        e.lat = 1; e.acc = 0; e.seen = 0;
        r = 0;
        case (op)
            4'd0:  e.res = a & b;
            4'd1:  e.res = a | b;
            4'd12: e.res = ~(a | b);
            4'd13: e.res = ~(a & b);
            4'd2: begin
                s = {1'b0, a} + {1'b0, b};
                e.res = s[31:0]; e.cout = s[32];
                e.ovf = (a[31] == b[31]) && (s[31] != a[31]);
                e.lat = 9;
            end
            4'd6: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                e.res = s[31:0]; e.cout = s[32];
                e.ovf = (a[31] != b[31]) && (s[31] != a[31]);
                e.lat = 9;
            end
            4'd7: begin
                lt = $signed(a) < $signed(b);
                eq = (a == b);
                e.lat = 9;
`ifdef ALU_CMP_EXT_EN
                case (cmp)
                    3'd0: r = lt;
                    3'd1: r = !lt && !eq;
                    3'd2: r = lt || eq;
                    3'd3: r = !lt;
                    3'd4: r = !eq;
                    3'd6: r = eq;
                    default: begin r = 0; e.err = 1; e.lat = 1; end
                endcase
`else
                r = lt;
`endif
                e.res = {31'b0, r};
            end
            default: e.err = 1;
        endcase
        e.zero = (e.res == 0);
        return e;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) q.delete();
        else if (rsp_valid && rsp_ready && q.size() > 0) void'(q.pop_front());
    end

    // Every cycle: req_ready tracks "no outstanding op", and a held response matches the model.
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("req_ready", {31'b0, req_ready}, (q.size() == 0) ? 32'd1 : 32'd0);
            if (q.size() == 0) begin
                chk("rsp_valid_idle", {31'b0, rsp_valid}, 32'd0);
            end else if (rsp_valid) begin
                if (!q[0].seen) begin
                    chk("latency", cyc - q[0].acc, q[0].lat);
                    q[0].seen = 1;
                end
                chk("result", rsp_result, q[0].res);
                chk("zero", {31'b0, rsp_zero}, {31'b0, q[0].zero});
                chk("cout", {31'b0, rsp_cout}, {31'b0, q[0].cout});
                chk("overflow", {31'b0, rsp_overflow}, {31'b0, q[0].ovf});
                chk("err", {31'b0, rsp_err}, {31'b0, q[0].err});
            end
        end
    end

    task automatic junk();
        req_valid = 1'($urandom_range(0, 1));
        req_src1  = $urandom;
        req_src2  = $urandom;
        req_op    = 4'($urandom_range(0, 15));
        req_cmp   = 3'($urandom_range(0, 7));
    endtask

    task automatic send_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] cmp);
        exp_t e;
        int g;
        g = 0;
        req_valid = 1; req_op = op; req_src1 = a; req_src2 = b; req_cmp = cmp;
        rsp_ready = 1'($urandom_range(0, 1));
        while (!req_ready) begin
            if (g > 20) begin
                chk("accept_timeout", g, 0);
                finish_run();
                return;
            end
            @(negedge clk);
            g++;
        end
        @(posedge clk);
        e = model(op, a, b, cmp);
        e.acc = cyc;
        q.push_back(e);
        @(negedge clk);
        req_valid = 0;
    endtask

    task automatic wait_rsp(input int hold, output rsp_t got, output int wcnt);
        wcnt = 0;
        got.res = '0; got.zero = 0; got.cout = 0; got.ovf = 0; got.err = 0;
        while (!rsp_valid) begin
            if (wcnt > 20) begin
                chk("rsp_timeout", wcnt, 0);
                finish_run();
                return;
            end
            junk();
            rsp_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            wcnt++;
        end
        got.res = rsp_result; got.zero = rsp_zero; got.cout = rsp_cout;
        got.ovf = rsp_overflow; got.err = rsp_err;
        for (int i = 0; i < hold; i++) begin
            rsp_ready = 0;
            junk();
            @(negedge clk);
        end
        rsp_ready = 1;
        req_valid = 0;
        @(negedge clk);
        rsp_ready = 0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h7FFFFFFF;
            3: return 32'h80000000;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rsp_t got;
        int   w;
        logic [3:0] ops [10];
        logic [3:0] op;
        logic [31:0] a, b;
        ops = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd13, 4'd3, 4'd4, 4'd15};

        rst_n = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_result", rsp_result, 32'd0);
        chk("rst_flags", {28'b0, rsp_zero, rsp_cout, rsp_overflow, rsp_err}, 32'd0);
        chk_en = 1;

        send_req(4'd2, 32'h7FFFFFFF, 32'h00000001, 3'd0);
        wait_rsp(0, got, w);
        chk("add_wait", w, 8);
        chk("add_res", got.res, 32'h80000000);
        chk("add_flags", {28'b0, got.zero, got.cout, got.ovf, got.err}, 32'b0010);

        send_req(4'd6, 32'h5, 32'h5, 3'd0);
        wait_rsp(0, got, w);
        chk("sub_res", got.res, 32'h0);
        chk("sub_flags", {28'b0, got.zero, got.cout, got.ovf, got.err}, 32'b1100);

        send_req(4'd0, 32'hF0F0F0F0, 32'hFF00FF00, 3'd0);
        wait_rsp(0, got, w);
        chk("and_wait", w, 0);
        chk("and_res", got.res, 32'hF000F000);

        send_req(4'd7, 32'hFFFFFFFF, 32'h1, 3'd0);
        wait_rsp(1, got, w);
        chk("slt_res", got.res, 32'h1);
`ifdef ALU_CMP_EXT_EN
        send_req(4'd7, 32'hFFFFFFFF, 32'h1, 3'd3);
        wait_rsp(0, got, w);
        chk("sge_res", got.res, 32'h0);
        send_req(4'd7, 32'h3, 32'h3, 3'd6);
        wait_rsp(0, got, w);
        chk("seq_res", got.res, 32'h1);
        send_req(4'd7, 32'h3, 32'h3, 3'd5);
        wait_rsp(0, got, w);
        chk("badcmp_err", {31'b0, got.err}, 32'd1);
        chk("badcmp_wait", w, 0);
`else
        send_req(4'd7, 32'h2, 32'h2, 3'd6);
        wait_rsp(0, got, w);
        chk("cmp6_res", got.res, 32'h0);
        chk("cmp6_err", {31'b0, got.err}, 32'd0);
`endif

        send_req(4'd12, 32'h0, 32'h0, 3'd0);
        wait_rsp(5, got, w);
        chk("nor_res", got.res, 32'hFFFFFFFF);
        chk("bp_req_ready", {31'b0, req_ready}, 32'd1);

        send_req(4'd2, $urandom, $urandom, 3'd0);
        repeat (4) @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        chk("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("abort_result", rsp_result, 32'd0);
        chk("abort_flags", {28'b0, rsp_zero, rsp_cout, rsp_overflow, rsp_err}, 32'd0);
        chk("abort_req_ready", {31'b0, req_ready}, 32'd1);
        repeat (3) @(negedge clk);

        send_req(4'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd0);
        wait_rsp(0, got, w);
        chk("nand_res", got.res, 32'h0);
        chk("nand_zero", {31'b0, got.zero}, 32'd1);

        send_req(4'd3, 32'h1234, 32'h5678, 3'd0);
        wait_rsp(0, got, w);
        chk("illegal_wait", w, 0);
        chk("illegal_res", got.res, 32'h0);
        chk("illegal_flags", {28'b0, got.zero, got.cout, got.ovf, got.err}, 32'b1001);

        for (int n = 0; n < 300; n++) begin
            op = ops[$urandom_range(0, 9)];
            a  = pick();
            b  = ($urandom_range(0, 7) == 0) ? a : pick();
            send_req(op, a, b, 3'($urandom_range(0, 7)));
            wait_rsp($urandom_range(0, 3), got, w);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        finish_run();
    end

endmodule
